alu_shifter: RTL and testbench
==============================

# alu_shifter

Single-position shifter for the 4-bit 74181-style ALU datapath. It provides a purely combinational shift-left-by-one output. It also provides a registered, op-selectable shift path (logical left/right, arithmetic right, rotate left) with carry-out and a valid flag. The block sits beside the ALU core and feeds doubled operands and shifted results back into the datapath.

## Interface
- WIDTH, default 4, datapath width in bits (minimum 2).
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  reset; synchronous and active-high.
- a  input  WIDTH  operand.
- a_s  output  WIDTH  combinational shift-left-by-one of a.
- in_valid  input  1  capture request for the registered path.
- op  input  2  registered-path operation, type shift_op_e.
- out_q  output  WIDTH  registered shift result.
- carry_q  output  1  registered bit shifted out.
- out_valid  output  1  out_q/carry_q updated this cycle.

## Operation
- a_s = {a[WIDTH-2:0], 1'b0}.
  - This is a*2 mod 2^WIDTH; the MSB is discarded.
  - a_s depends only on a; clk, rst, in_valid and op never affect it.
  - a_s is valid even when all other inputs are unconnected or X/Z.
- Registered path, selected by op:
  - SHL (2'b00): out = {a[W-2:0], 0}, carry = a[W-1].
  - SHR (2'b01): out = {0, a[W-1:1]}, carry = a[0].
  - ASR (2'b10): out = {a[W-1], a[W-1:1]}, carry = a[0].
  - ROL (2'b11): out = {a[W-2:0], a[W-1]}, carry = a[W-1].
- All arithmetic is unsigned WIDTH-bit. No widening and no saturation.

## Timing
- a_s: zero-cycle combinational; settles within the same delta/time step as a.
- Registered path: 1-cycle latency. On a rising clk edge with in_valid=1 and rst=0:
  - out_q and carry_q load the op result computed from the current a.
  - out_valid is 1 for the following cycle.
- in_valid=0: out_q and carry_q hold their values; out_valid = 0.
- Reset:
  - At a rising edge with rst=1: out_q = 0, carry_q = 0, out_valid = 0.
  - rst dominates a simultaneous in_valid.
  - a_s is unaffected by reset.
- Back-to-back in_valid is accepted every cycle. There is no backpressure.

## Structure
- Shared package alu_pkg:
  - shift_op_e enum: SHL, SHR, ASR, ROL, with the 2-bit encodings above.
  - Default width constant ALU_WIDTH = 4.
- Sub-module shift_core: combinational, parameterized by WIDTH.
  - Inputs: a, op. Outputs: result, carry.
  - It is instantiated once for the registered path.
- a_s is driven by a dedicated SHL expression, independent of op, so it stays correct with op unconnected.

## Test plan
- Exhaustive combinational check, clk idle, a = 0..15, each checked 1 time unit after applying a:
  - a_s = (2a) mod 16, e.g. a=0111 -> 1110, a=1000 -> 0000, a=1111 -> 1110.
- Reset: rst=1 for 2 edges with in_valid=1, a=1111 -> out_q=0000, carry_q=0, out_valid=0.
- Registered ops, a=1011 with in_valid=1, one edge each:
  - SHL -> 0110, c=1.
  - SHR -> 0101, c=1.
  - ASR -> 1101, c=1.
  - ROL -> 0111, c=1.
- Hold: after loading 0110, drop in_valid and change a -> out_q stays 0110, out_valid=0.
- Back-to-back SHL captures of a = 0001, 0010, 0100, 1000 -> out_q = 0010, 0100, 1000, 0000, with carry 0, 0, 0, 1 on consecutive cycles.
- Simultaneous rst=1 and in_valid=1 -> all registered outputs 0, while a_s still equals (2a) mod 16.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the 74181-style ALU datapath.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        SHL = 2'b00,
        SHR = 2'b01,
        ASR = 2'b10,
        ROL = 2'b11
    } shift_op_e;

endpackage

// File: rtl/alu_shifter_if.sv
// Operand/result bundle between the datapath and the shifter.
interface alu_shifter_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] a_s;
    logic             in_valid;
    shift_op_e        op;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             out_valid;

    modport master (
        output a, in_valid, op,
        input  a_s, out_q, carry_q, out_valid
    );

    modport slave (
        input  a, in_valid, op,
        output a_s, out_q, carry_q, out_valid
    );

endinterface

// File: rtl/shift_core.sv
// Combinational single-position shift/rotate with the shifted-out bit as carry.
module shift_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (op)
            SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            ASR: begin
                result = {a[WIDTH-1], a[WIDTH-1:1]};
                carry  = a[0];
            end
            ROL: begin
                result = {a[WIDTH-2:0], a[WIDTH-1]};
                carry  = a[WIDTH-1];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_shifter.sv
// Shifter beside the ALU core: combinational doubling of a plus a registered,
// op-selectable shift path with carry-out and a one-cycle valid flag.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input logic           clk,
    input logic           rst,
    alu_shifter_if.slave  bus
);

    logic [WIDTH-1:0] w_result;
    logic             w_carry;

    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_valid;

    // Kept separate from shift_core so it never depends on op.
    assign bus.a_s = {bus.a[WIDTH-2:0], 1'b0};

    shift_core #(
        .WIDTH (WIDTH)
    ) u_shift_core (
        .a      (bus.a),
        .op     (bus.op),
        .result (w_result),
        .carry  (w_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out   <= w_result;
                r_carry <= w_carry;
            end
        end
    end

    assign bus.out_q     = r_out;
    assign bus.carry_q   = r_carry;
    assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_alu_shifter.sv
// Self-checking bench for alu_shifter: directed steps plus a randomized run
// against an arithmetic reference model.
module tb_alu_shifter;
    import alu_pkg::*;

    localparam int unsigned W = 4;

    logic clk;
    logic clk_en;
    logic rst;

    int checks;
    int failures;

    alu_shifter_if #(.WIDTH(W)) bus ();

    alu_shifter #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    // Reference model: plain unsigned arithmetic on 4-bit values.
    function automatic int ref_out(input shift_op_e o, input int x);
        case (o)
            SHL:     return (x * 2) % 16;
            SHR:     return x / 2;
            ASR:     return x / 2 + ((x >= 8) ? 8 : 0);
            default: return (x * 2) % 16 + x / 8;
        endcase
    endfunction

    function automatic int ref_carry(input shift_op_e o, input int x);
        if (o == SHL || o == ROL) return x / 8;
        return x % 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input shift_op_e o, input int x);
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.op       = o;
        bus.a        = W'(x);
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input int eo, input int ec, input int ev);
        check({tag, "_out"}, {28'd0, bus.out_q}, eo);
        check({tag, "_carry"}, {31'd0, bus.carry_q}, ec);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, ev);
    endtask

    int        exp_out;
    int        exp_carry;
    int        exp_valid;
    logic      rr;
    logic      vv;
    shift_op_e oo;
    int        xx;

    initial begin
        checks   = 0;
        failures = 0;
        clk_en   = 1'b0;

        // Combinational doubling with clock idle and other inputs left unknown.
        for (int i = 0; i < 16; i++) begin
            bus.a = W'(i);
            #1;
            check($sformatf("a_s_comb_%0d", i), {28'd0, bus.a_s}, (i * 2) % 16);
        end

        clk_en = 1'b1;

        step(1'b1, 1'b1, SHL, 15);
        step(1'b1, 1'b1, SHL, 15);
        check_regs("reset", 0, 0, 0);

        step(1'b0, 1'b1, SHL, 11);
        check_regs("shl_1011", 6, 1, 1);
        step(1'b0, 1'b1, SHR, 11);
        check_regs("shr_1011", 5, 1, 1);
        step(1'b0, 1'b1, ASR, 11);
        check_regs("asr_1011", 13, 1, 1);
        step(1'b0, 1'b1, ROL, 11);
        check_regs("rol_1011", 7, 1, 1);

        step(1'b0, 1'b1, SHL, 11);
        check_regs("load_0110", 6, 1, 1);
        step(1'b0, 1'b0, SHR, 4);
        check_regs("hold", 6, 1, 0);
        step(1'b0, 1'b0, ROL, 9);
        check_regs("hold2", 6, 1, 0);

        step(1'b0, 1'b1, SHL, 1);
        check_regs("b2b_0001", 2, 0, 1);
        step(1'b0, 1'b1, SHL, 2);
        check_regs("b2b_0010", 4, 0, 1);
        step(1'b0, 1'b1, SHL, 4);
        check_regs("b2b_0100", 8, 0, 1);
        step(1'b0, 1'b1, SHL, 8);
        check_regs("b2b_1000", 0, 1, 1);

        step(1'b1, 1'b1, ROL, 13);
        check_regs("rst_vs_valid", 0, 0, 0);
        check("rst_a_s", {28'd0, bus.a_s}, 10);

        exp_out   = 0;
        exp_carry = 0;
        exp_valid = 0;
        for (int i = 0; i < 80; i++) begin
            rr = ($urandom_range(0, 7) == 0);
            vv = 1'($urandom_range(0, 1));
            oo = shift_op_e'($urandom_range(0, 3));
            xx = int'($urandom_range(0, 15));
            step(rr, vv, oo, xx);
            if (rr) begin
                exp_out   = 0;
                exp_carry = 0;
                exp_valid = 0;
            end else begin
                exp_valid = vv ? 1 : 0;
                if (vv) begin
                    exp_out   = ref_out(oo, xx);
                    exp_carry = ref_carry(oo, xx);
                end
            end
            check_regs($sformatf("rand%0d", i), exp_out, exp_carry, exp_valid);
            check($sformatf("rand%0d_a_s", i), {28'd0, bus.a_s}, (xx * 2) % 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
